// File: rtl/rule_pair_matcher.sv
// rule_pair_matcher: scans a 256-entry rule table two rules/clock per header, emitting ena/startRule framed verdict pairs.
// Pair k appears 2 cycles after its read issues; headers/writes back-pressured during a scan; `RULE_HIT_COUNT_EN adds hit_count.
module rule_pair_matcher #(
    parameter int NUM_RULES = 256,
    parameter int HDR_W     = 104,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HDR_W-1:0]  hdr,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic              rule_we,
    input  logic [ADDR_W-1:0] rule_addr,
    input  logic [HDR_W-1:0]  rule_value,
    input  logic [HDR_W-1:0]  rule_mask,
    input  logic              rule_valid,
    output logic              rule_wr_ready,
    output logic              ena,
    output logic              startRule,
    output logic              isAccept1,
    output logic              isAccept2,
`ifdef RULE_HIT_COUNT_EN
    output logic [31:0]       hit_count,
    input  logic              hit_count_clr,
`endif
    output logic              busy
);

    localparam int PAIRS  = NUM_RULES / 2;
    localparam int PAIR_W = ADDR_W - 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state;
    logic [PAIR_W-1:0]  pair_idx;
    logic [HDR_W-1:0]   hdr_q;

    logic [HDR_W-1:0]   even_value [PAIRS];
    logic [HDR_W-1:0]   even_mask  [PAIRS];
    logic [HDR_W-1:0]   odd_value  [PAIRS];
    logic [HDR_W-1:0]   odd_mask   [PAIRS];
    logic [NUM_RULES-1:0] valid_q;

    logic [HDR_W-1:0]   rd_even_value;
    logic [HDR_W-1:0]   rd_even_mask;
    logic [HDR_W-1:0]   rd_odd_value;
    logic [HDR_W-1:0]   rd_odd_mask;

    logic               s1_ena;
    logic               s1_start;
    logic               s1_v_even;
    logic               s1_v_odd;
    logic [HDR_W-1:0]   s1_hdr;

    logic               hs;
    logic               wr_fire;
    logic               issue;
    logic               issue_start;
    logic [PAIR_W-1:0]  issue_idx;
    logic [HDR_W-1:0]   issue_hdr;
    logic               deny_even;
    logic               deny_odd;

    // A header arriving on the last issue slot starts its pair 0 next cycle, so hdr_q only feeds SCAN issues.
    always_comb begin
        hdr_ready     = (state == IDLE) ? ~rule_we : (pair_idx == LAST_PAIR);
        rule_wr_ready = (state == IDLE);
        hs            = hdr_valid && hdr_ready;
        wr_fire       = rule_we && rule_wr_ready;
        issue         = (state == SCAN) || hs;
        issue_idx     = (state == IDLE) ? '0 : pair_idx;
        issue_hdr     = (state == IDLE) ? hdr : hdr_q;
        issue_start   = (issue_idx == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pair_idx <= '0;
            hdr_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        hdr_q    <= hdr;
                        pair_idx <= PAIR_W'(1);
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    pair_idx <= pair_idx + 1'b1;
                    if (pair_idx == LAST_PAIR) begin
                        if (hs) begin
                            hdr_q <= hdr;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Value/mask banks are plain RAM: no reset, one synchronous read per bank per cycle.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            if (rule_addr[0]) begin
                odd_value[rule_addr[ADDR_W-1:1]] <= rule_value;
                odd_mask[rule_addr[ADDR_W-1:1]]  <= rule_mask;
            end else begin
                even_value[rule_addr[ADDR_W-1:1]] <= rule_value;
                even_mask[rule_addr[ADDR_W-1:1]]  <= rule_mask;
            end
        end
        rd_even_value <= even_value[issue_idx];
        rd_even_mask  <= even_mask[issue_idx];
        rd_odd_value  <= odd_value[issue_idx];
        rd_odd_mask   <= odd_mask[issue_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_fire) begin
            valid_q[rule_addr] <= rule_valid;
        end
    end

    // The header travels with its read so overlapping packets compare against their own header.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ena    <= 1'b0;
            s1_start  <= 1'b0;
            s1_v_even <= 1'b0;
            s1_v_odd  <= 1'b0;
            s1_hdr    <= '0;
        end else begin
            s1_ena    <= issue;
            s1_start  <= issue && issue_start;
            s1_v_even <= valid_q[{issue_idx, 1'b0}];
            s1_v_odd  <= valid_q[{issue_idx, 1'b1}];
            if (issue) begin
                s1_hdr <= issue_hdr;
            end
        end
    end

    assign deny_even = s1_v_even && (((s1_hdr ^ rd_even_value) & rd_even_mask) == '0);
    assign deny_odd  = s1_v_odd  && (((s1_hdr ^ rd_odd_value)  & rd_odd_mask)  == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ena       <= 1'b0;
            startRule <= 1'b0;
            isAccept1 <= 1'b0;
            isAccept2 <= 1'b0;
        end else begin
            ena       <= s1_ena;
            startRule <= s1_ena && s1_start;
            isAccept1 <= s1_ena && !deny_even;
            isAccept2 <= s1_ena && !deny_odd;
        end
    end

    assign busy = (state == SCAN) || s1_ena || ena;

`ifdef RULE_HIT_COUNT_EN
    logic [32:0] hit_sum;

    always_comb begin
        hit_sum = {1'b0, hit_count} + 33'(ena & ~isAccept1) + 33'(ena & ~isAccept2);
    end

    always_ff @(posedge clk) begin
        if (rst || hit_count_clr) begin
            hit_count <= '0;
        end else if (ena) begin
            hit_count <= hit_sum[32] ? '1 : hit_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_rule_pair_matcher.sv
// Bench for rule_pair_matcher: directed test-plan steps plus a randomized phase, checked per cycle against a rule-table model.
module tb_rule_pair_matcher;
    localparam int HDR_W = 104;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [HDR_W-1:0] hdr;
    logic             hdr_valid;
    logic             hdr_ready;
    logic             rule_we;
    logic [7:0]       rule_addr;
    logic [HDR_W-1:0] rule_value;
    logic [HDR_W-1:0] rule_mask;
    logic             rule_valid;
    logic             rule_wr_ready;
    logic             ena;
    logic             startRule;
    logic             isAccept1;
    logic             isAccept2;
    logic             busy;
`ifdef RULE_HIT_COUNT_EN
    logic [31:0]      hit_count;
    logic             hit_count_clr;
`endif

    rule_pair_matcher dut (
        .clk           (clk),
        .rst           (rst),
        .hdr           (hdr),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .rule_we       (rule_we),
        .rule_addr     (rule_addr),
        .rule_value    (rule_value),
        .rule_mask     (rule_mask),
        .rule_valid    (rule_valid),
        .rule_wr_ready (rule_wr_ready),
        .ena           (ena),
        .startRule     (startRule),
        .isAccept1     (isAccept1),
        .isAccept2     (isAccept2),
`ifdef RULE_HIT_COUNT_EN
        .hit_count     (hit_count),
        .hit_count_clr (hit_count_clr),
`endif
        .busy          (busy)
    );

    typedef struct {
        int cyc;
        bit st;
        bit a1;
        bit a2;
    } pair_t;

    logic [HDR_W-1:0] m_value [256];
    logic [HDR_W-1:0] m_mask  [256];
    bit               m_valid [256];
    pair_t            pend[$];
    int               cyc;
    int               last_hs, last_i0, prev_hs, prev_i0;
    int               compared, mismatched;
    bit               hs_seen, wr_seen;
    longint           hc_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit denies(input logic [HDR_W-1:0] h, input int i);
        if (!m_valid[i]) return 1'b0;
        return (((h ^ m_value[i]) & m_mask[i]) == '0);
    endfunction

    function automatic logic [HDR_W-1:0] rand_hdr();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[HDR_W-1:0];
    endfunction

    function automatic logic [HDR_W-1:0] field_mask(input logic [4:0] sel);
        logic [HDR_W-1:0] m;
        m = '0;
        if (sel[4]) m[103:72] = '1;
        if (sel[3]) m[71:40]  = '1;
        if (sel[2]) m[39:24]  = '1;
        if (sel[1]) m[23:8]   = '1;
        if (sel[0]) m[7:0]    = '1;
        return m;
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        last_hs  = -1000;
        last_i0  = -1000;
        prev_hs  = -1000;
        prev_i0  = -1000;
        hc_model = 0;
    endtask

    // One clock: check outputs mid-cycle, advance the model by what this cycle accepts, then cross the edge.
    task automatic cycle();
        bit    e_ena, e_st, e_a1, e_a2, e_hr, e_wr, e_busy, scanning, pop;
        int    i0;
        pair_t p;
        #4;
        e_ena = 0; e_st = 0; e_a1 = 0; e_a2 = 0; pop = 0;
        p = '{0, 0, 0, 0};
        if (pend.size() > 0 && pend[0].cyc == cyc) begin
            p = pend[0];
            e_ena = 1; e_st = p.st; e_a1 = p.a1; e_a2 = p.a2; pop = 1;
        end
        scanning = (cyc > last_hs) && (cyc <= last_i0 + 127);
        e_hr     = scanning ? (cyc == last_i0 + 127) : !rule_we;
        e_wr     = !scanning;
        e_busy   = (cyc > last_hs && cyc <= last_i0 + 129) || (cyc > prev_hs && cyc <= prev_i0 + 129);
        chk("ena",           32'(ena),           32'(e_ena));
        chk("startRule",     32'(startRule),     32'(e_st));
        chk("isAccept1",     32'(isAccept1),     32'(e_a1));
        chk("isAccept2",     32'(isAccept2),     32'(e_a2));
        chk("busy",          32'(busy),          32'(e_busy));
        chk("hdr_ready",     32'(hdr_ready),     32'(e_hr));
        chk("rule_wr_ready", 32'(rule_wr_ready), 32'(e_wr));
`ifdef RULE_HIT_COUNT_EN
        chk("hit_count", hit_count, hc_model[31:0]);
`endif
        hs_seen = !rst && hdr_valid && e_hr;
        wr_seen = !rst && rule_we && e_wr;
        if (hs_seen) begin
            i0 = scanning ? cyc + 1 : cyc;
            for (int k = 0; k < 128; k++) begin
                pair_t q;
                q.cyc = i0 + 2 + k;
                q.st  = (k == 0);
                q.a1  = !denies(hdr, 2 * k);
                q.a2  = !denies(hdr, 2 * k + 1);
                pend.push_back(q);
            end
            prev_hs = last_hs; prev_i0 = last_i0;
            last_hs = cyc;     last_i0 = i0;
        end
        if (pop) begin
            void'(pend.pop_front());
            hc_model = hc_model + (p.a1 ? 0 : 1) + (p.a2 ? 0 : 1);
            if (hc_model > 64'h0000_0000_FFFF_FFFF) hc_model = 64'h0000_0000_FFFF_FFFF;
        end
        if (wr_seen) begin
            m_value[rule_addr] = rule_value;
            m_mask[rule_addr]  = rule_mask;
            m_valid[rule_addr] = rule_valid;
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic send_hdr(input logic [HDR_W-1:0] h);
        int n;
        n = 0;
        hdr = h;
        hdr_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!hs_seen && n < 300);
        hdr_valid = 1'b0;
        chk("hdr_accept_timeout", 32'(hs_seen), 32'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [HDR_W-1:0] v,
                            input logic [HDR_W-1:0] m, input logic vl);
        int n;
        n = 0;
        rule_addr = a; rule_value = v; rule_mask = m; rule_valid = vl;
        rule_we = 1'b1;
        do begin
            cycle();
            n++;
        end while (!wr_seen && n < 300);
        rule_we = 1'b0;
        chk("write_accept_timeout", 32'(wr_seen), 32'd1);
    endtask

    initial begin
        logic [HDR_W-1:0] h, h2, base;
        int sel, gap;
        rst = 1'b1; hdr = '0; hdr_valid = 1'b0;
        rule_we = 1'b0; rule_addr = '0; rule_value = '0; rule_mask = '0; rule_valid = 1'b0;
`ifdef RULE_HIT_COUNT_EN
        hit_count_clr = 1'b0;
`endif
        cyc = 0; compared = 0; mismatched = 0; hs_seen = 0; wr_seen = 0;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        idle(2);

        // Empty table: every pair accepts.
        send_hdr(rand_hdr());
        idle(135);

        // Rule 0 matches proto 6 only.
        do_write(8'd0, 104'd6, 104'hFF, 1'b1);
        h = rand_hdr(); h[7:0] = 8'd6;
        send_hdr(h);
        idle(132);
        h[7:0] = 8'd17;
        send_hdr(h);
        idle(132);

        // Rule 255 with an empty mask denies every header.
        do_write(8'd255, rand_hdr(), '0, 1'b1);
        send_hdr(rand_hdr());
        idle(132);

        // Second header offered while the first scans.
        h = rand_hdr(); h[7:0] = 8'd6;
        h2 = rand_hdr(); h2[7:0] = 8'd17;
        send_hdr(h);
        send_hdr(h2);
        idle(260);

        // Write requested mid-scan waits for the scan to end, then applies to the next packet.
        h = rand_hdr(); h[7:0] = 8'd17;
        send_hdr(h);
        do_write(8'd3, h, field_mask(5'b00010), 1'b1);
        send_hdr(h);
        idle(132);

        // Reset while pair 50 is presented.
        h = rand_hdr(); h[7:0] = 8'd6;
        send_hdr(h);
        idle(51);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(3);
        send_hdr(h);
        idle(132);

        // Randomized rules derived from one base header, then a burst of related headers.
        base = rand_hdr();
        for (int r = 0; r < 20; r++) begin
            do_write(8'($urandom_range(1, 254)), base,
                     field_mask(5'($urandom_range(1, 31))), ($urandom_range(0, 3) != 0));
        end
        for (int pkt = 0; pkt < 6; pkt++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) h = base;
            else if (sel == 1) h = base ^ (104'd1 << $urandom_range(0, 103));
            else h = rand_hdr();
            send_hdr(h);
            gap = $urandom_range(0, 2);
            idle(gap);
        end
        idle(270);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
